// File: rtl/ara_pe_req_queue_if.sv
// Purpose : request/issue/commit signal bundle between the sequencer, one PE queue and its datapath.
// Latency : n/a (wires only).
// Backpressure: pe_req_ready_o toward the sequencer, issue_ready_i from the datapath.
// Ports   : slave = queue view (requests, running set, issue ready and exec done in; ready, issue and done out);
//           master = environment view (mirror of slave).
interface ara_pe_req_queue_if #(
    parameter int unsigned NrVInsn  = 8,
    parameter int unsigned IdWidth  = $clog2(NrVInsn),
    parameter int unsigned VlWidth  = 16,
    parameter int unsigned VfuWidth = 3
);
    logic                pe_req_valid_i;
    logic                pe_req_ready_o;
    logic [IdWidth-1:0]  pe_req_id_i;
    logic [VfuWidth-1:0] pe_req_vfu_i;
    logic [VlWidth-1:0]  pe_req_vl_i;
    logic [NrVInsn-1:0]  pe_req_hazard_i;
    logic [NrVInsn-1:0]  vinsn_running_i;
    logic                issue_valid_o;
    logic                issue_ready_i;
    logic [IdWidth-1:0]  issue_id_o;
    logic [VlWidth-1:0]  issue_vl_o;
    logic                exec_done_i;
    logic [NrVInsn-1:0]  vinsn_done_o;
    logic [NrVInsn-1:0]  vinsn_inflight_o;

    modport slave (
        input  pe_req_valid_i, pe_req_id_i, pe_req_vfu_i, pe_req_vl_i, pe_req_hazard_i,
        input  vinsn_running_i, issue_ready_i, exec_done_i,
        output pe_req_ready_o, issue_valid_o, issue_id_o, issue_vl_o, vinsn_done_o, vinsn_inflight_o
    );

    modport master (
        output pe_req_valid_i, pe_req_id_i, pe_req_vfu_i, pe_req_vl_i, pe_req_hazard_i,
        output vinsn_running_i, issue_ready_i, exec_done_i,
        input  pe_req_ready_o, issue_valid_o, issue_id_o, issue_vl_o, vinsn_done_o, vinsn_inflight_o
    );
endinterface

// File: rtl/ara_pe_req_queue.sv
// Purpose : per-PE in-order request queue; holds entries until their hazard mask clears, issues in order, retires with done pulses.
// Latency : accept->issue_valid 1 cycle (0 with ARA_PE_REQ_QUEUE_BYPASS_EN on an empty, hazard-free queue); exec_done->done pulse 1 cycle.
// Backpressure: pe_req_ready_o = !full from registered occupancy; entries wait at the issue pointer while issue_ready_i is low.
// Ports   : clk_i, rst_ni (async active-low); bus (slave modport of ara_pe_req_queue_if).
// Option  : `define ARA_PE_REQ_QUEUE_BYPASS_EN for same-cycle issue when no un-issued entry is waiting.
module ara_pe_req_queue #(
    parameter int unsigned NrVInsn  = 8,
    parameter int unsigned IdWidth  = $clog2(NrVInsn),
    parameter int unsigned Depth    = 4,
    parameter int unsigned VlWidth  = 16,
    parameter int unsigned VfuWidth = 3,
    parameter int unsigned MyVfu    = 0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    ara_pe_req_queue_if.slave  bus
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [NrVInsn-1:0] OneHot0 = NrVInsn'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    typedef logic [PtrW:0] ptr_t;

    ptr_t                r_acc, r_iss, r_com;
    logic [IdWidth-1:0]  r_id  [Depth];
    logic [VlWidth-1:0]  r_vl  [Depth];
    logic [NrVInsn-1:0]  r_haz [Depth];
    logic [NrVInsn-1:0]  r_inflight;
    logic [NrVInsn-1:0]  r_done;

    logic [PtrW-1:0]     w_acc_idx, w_iss_idx, w_com_idx;
    logic                w_full;
    logic                w_acc;
    logic                w_pend;
    logic                w_reg_vld;
    logic                w_commit;
    logic                w_iss_fire;
    logic                w_issue_vld;
    logic [IdWidth-1:0]  w_issue_id;
    logic [VlWidth-1:0]  w_issue_vl;
    logic [NrVInsn-1:0]  w_new_haz;
    logic [NrVInsn-1:0]  w_set, w_clr;

    assign w_acc_idx = r_acc[PtrW-1:0];
    assign w_iss_idx = r_iss[PtrW-1:0];
    assign w_com_idx = r_com[PtrW-1:0];

    assign w_full = (r_acc[PtrW] != r_com[PtrW]) && (w_acc_idx == w_com_idx);

    // The in-flight check stops re-capturing a request the sequencer keeps
    // valid while other PEs are still not ready.
    assign w_acc = bus.pe_req_valid_i && !w_full
                && (bus.pe_req_vfu_i == VfuWidth'(MyVfu))
                && !r_inflight[bus.pe_req_id_i];

    // Bits already retired from the running set can never block this entry.
    assign w_new_haz = bus.pe_req_hazard_i & bus.vinsn_running_i;

    assign w_pend    = (r_iss != r_acc);
    assign w_reg_vld = w_pend && (r_haz[w_iss_idx] == '0);
    assign w_commit  = bus.exec_done_i && (r_com != r_iss);

    always_comb begin
        w_issue_vld = w_reg_vld;
        w_issue_id  = r_id[w_iss_idx];
        w_issue_vl  = r_vl[w_iss_idx];
`ifdef ARA_PE_REQ_QUEUE_BYPASS_EN
        // Nothing older waits to issue, so the incoming request may go straight out.
        if (!w_pend && w_acc && (w_new_haz == '0)) begin
            w_issue_vld = 1'b1;
            w_issue_id  = bus.pe_req_id_i;
            w_issue_vl  = bus.pe_req_vl_i;
        end
`endif
    end

    // In bypass the entry is still written, just already past the issue pointer.
    assign w_iss_fire = w_issue_vld && bus.issue_ready_i;

    assign w_set = w_acc    ? (OneHot0 << bus.pe_req_id_i) : '0;
    assign w_clr = w_commit ? (OneHot0 << r_id[w_com_idx]) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc      <= '0;
            r_iss      <= '0;
            r_com      <= '0;
            r_inflight <= '0;
            r_done     <= '0;
        end else begin
            r_acc      <= r_acc + ptr_t'(w_acc);
            r_iss      <= r_iss + ptr_t'(w_iss_fire);
            r_com      <= r_com + ptr_t'(w_commit);
            // Accept never targets an ID still in flight, so set and clear are disjoint.
            r_inflight <= (r_inflight | w_set) & ~w_clr;
            r_done     <= w_clr;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                r_id[i]  <= '0;
                r_vl[i]  <= '0;
                r_haz[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (w_acc && (PtrW'(i) == w_acc_idx)) begin
                    r_id[i]  <= bus.pe_req_id_i;
                    r_vl[i]  <= bus.pe_req_vl_i;
                    r_haz[i] <= w_new_haz;
                end else begin
                    // Masks only shrink as instructions leave the running set.
                    r_haz[i] <= r_haz[i] & bus.vinsn_running_i;
                end
            end
        end
    end

    assign bus.pe_req_ready_o   = !w_full;
    assign bus.issue_valid_o    = w_issue_vld;
    assign bus.issue_id_o       = w_issue_id;
    assign bus.issue_vl_o       = w_issue_vl;
    assign bus.vinsn_done_o     = r_done;
    assign bus.vinsn_inflight_o = r_inflight;
endmodule

// File: tb/tb_ara_pe_req_queue.sv
module tb_ara_pe_req_queue;
`ifdef ARA_PE_REQ_QUEUE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ara_pe_req_queue_if #(.NrVInsn(8), .IdWidth(3), .VlWidth(16), .VfuWidth(3)) bus ();

    ara_pe_req_queue #(
        .NrVInsn(8), .IdWidth(3), .Depth(4), .VlWidth(16), .VfuWidth(3), .MyVfu(0)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.pe_req_valid_i  = 1'b0;
        bus.pe_req_id_i     = '0;
        bus.pe_req_vfu_i    = '0;
        bus.pe_req_vl_i     = '0;
        bus.pe_req_hazard_i = '0;
        bus.vinsn_running_i = '0;
        bus.exec_done_i     = 1'b0;
    endtask

    task automatic req(input logic [2:0] id, input logic [15:0] vl, input logic [2:0] vfu, input logic [7:0] haz);
        bus.pe_req_valid_i  = 1'b1;
        bus.pe_req_id_i     = id;
        bus.pe_req_vl_i     = vl;
        bus.pe_req_vfu_i    = vfu;
        bus.pe_req_hazard_i = haz;
    endtask

    task automatic test_reset();
        idle();
        bus.issue_ready_i = 1'b0;
        rst_n = 1'b0;
        #12;
        checks++; if (bus.pe_req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.pe_req_ready_o); end
        checks++; if (bus.issue_valid_o !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got %b exp 0", bus.issue_valid_o); end
        checks++; if (bus.issue_id_o !== 3'd0 || bus.issue_vl_o !== 16'd0) begin errors++; $display("FAIL reset_issue_bus got id %0d vl %0d exp 0 0", bus.issue_id_o, bus.issue_vl_o); end
        checks++; if (bus.vinsn_done_o !== 8'h00) begin errors++; $display("FAIL reset_done got %h exp 00", bus.vinsn_done_o); end
        checks++; if (bus.vinsn_inflight_o !== 8'h00) begin errors++; $display("FAIL reset_inflight got %h exp 00", bus.vinsn_inflight_o); end
        @(posedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_basic();
        logic v0, v1;
        logic [2:0] i0, i1;
        logic [15:0] l0, l1;
        idle();
        bus.issue_ready_i = 1'b1;
        req(3'd3, 16'd16, 3'd0, 8'h00);
        mid(); v0 = bus.issue_valid_o; i0 = bus.issue_id_o; l0 = bus.issue_vl_o; next_cyc();
        idle();
        mid(); v1 = bus.issue_valid_o; i1 = bus.issue_id_o; l1 = bus.issue_vl_o;
        checks++; if (v0 !== BYP) begin errors++; $display("FAIL basic_valid_accept_cycle got %b exp %b", v0, BYP); end
        checks++; if (v1 !== !BYP) begin errors++; $display("FAIL basic_valid_next_cycle got %b exp %b", v1, !BYP); end
        checks++; if ((BYP ? i0 : i1) !== 3'd3) begin errors++; $display("FAIL basic_issue_id got %0d exp 3", BYP ? i0 : i1); end
        checks++; if ((BYP ? l0 : l1) !== 16'd16) begin errors++; $display("FAIL basic_issue_vl got %0d exp 16", BYP ? l0 : l1); end
        checks++; if (bus.vinsn_inflight_o !== 8'h08) begin errors++; $display("FAIL basic_inflight got %h exp 08", bus.vinsn_inflight_o); end
        next_cyc();
        mid();
        checks++; if (bus.issue_valid_o !== 1'b0) begin errors++; $display("FAIL basic_after_issue got %b exp 0", bus.issue_valid_o); end
        next_cyc();
        bus.exec_done_i = 1'b1;
        mid();
        checks++; if (bus.vinsn_done_o !== 8'h00) begin errors++; $display("FAIL basic_done_early got %h exp 00", bus.vinsn_done_o); end
        next_cyc();
        bus.exec_done_i = 1'b0;
        mid();
        checks++; if (bus.vinsn_done_o !== 8'h08) begin errors++; $display("FAIL basic_done_pulse got %h exp 08", bus.vinsn_done_o); end
        checks++; if (bus.vinsn_inflight_o !== 8'h00) begin errors++; $display("FAIL basic_inflight_clear got %h exp 00", bus.vinsn_inflight_o); end
        next_cyc();
        mid();
        checks++; if (bus.vinsn_done_o !== 8'h00) begin errors++; $display("FAIL basic_done_one_cycle got %h exp 00", bus.vinsn_done_o); end
        next_cyc();
    endtask

    task automatic test_duplicate_hold();
        int n = 0;
        idle();
        bus.issue_ready_i = 1'b0;
        req(3'd5, 16'd8, 3'd0, 8'h00);
        for (int k = 0; k < 3; k++) next_cyc();
        idle();
        mid();
        checks++; if (bus.vinsn_inflight_o !== 8'h20) begin errors++; $display("FAIL dup_inflight got %h exp 20", bus.vinsn_inflight_o); end
        next_cyc();
        bus.issue_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mid();
            if (bus.issue_valid_o) n++;
            next_cyc();
        end
        checks++; if (n !== 1) begin errors++; $display("FAIL dup_issue_count got %0d exp 1", n); end
        bus.issue_ready_i = 1'b0;
        bus.exec_done_i = 1'b1;
        next_cyc();
        bus.exec_done_i = 1'b0;
        mid();
        checks++; if (bus.vinsn_done_o !== 8'h20) begin errors++; $display("FAIL dup_done got %h exp 20", bus.vinsn_done_o); end
        checks++; if (bus.vinsn_inflight_o !== 8'h00) begin errors++; $display("FAIL dup_inflight_clear got %h exp 00", bus.vinsn_inflight_o); end
        next_cyc();
        // Nothing issued and uncommitted: this done must be ignored.
        bus.exec_done_i = 1'b1;
        next_cyc();
        bus.exec_done_i = 1'b0;
        mid();
        checks++; if (bus.vinsn_done_o !== 8'h00) begin errors++; $display("FAIL dup_spurious_done got %h exp 00", bus.vinsn_done_o); end
        next_cyc();
    endtask

    task automatic test_hazard();
        idle();
        bus.issue_ready_i = 1'b1;
        bus.vinsn_running_i = 8'h01;
        req(3'd2, 16'd4, 3'd0, 8'h01);
        mid();
        checks++; if (bus.issue_valid_o !== 1'b0) begin errors++; $display("FAIL haz_accept_cycle got %b exp 0", bus.issue_valid_o); end
        next_cyc();
        bus.pe_req_valid_i = 1'b0;
        for (int k = 1; k < 4; k++) begin
            mid();
            checks++; if (bus.issue_valid_o !== 1'b0) begin errors++; $display("FAIL haz_blocked_%0d got %b exp 0", k, bus.issue_valid_o); end
            next_cyc();
        end
        bus.vinsn_running_i = 8'h00;
        mid();
        checks++; if (bus.issue_valid_o !== 1'b0) begin errors++; $display("FAIL haz_drop_cycle got %b exp 0", bus.issue_valid_o); end
        next_cyc();
        mid();
        checks++; if (bus.issue_valid_o !== 1'b1 || bus.issue_id_o !== 3'd2) begin errors++; $display("FAIL haz_release got valid %b id %0d exp 1 2", bus.issue_valid_o, bus.issue_id_o); end
        next_cyc();
        bus.issue_ready_i = 1'b0;
        bus.exec_done_i = 1'b1;
        next_cyc();
        bus.exec_done_i = 1'b0;
        mid();
        checks++; if (bus.vinsn_done_o !== 8'h04) begin errors++; $display("FAIL haz_done got %h exp 04", bus.vinsn_done_o); end
        next_cyc();
    endtask

    task automatic test_full();
        idle();
        bus.issue_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req(3'(k), 16'(k + 1), 3'd0, 8'h00);
            mid();
            checks++; if (bus.pe_req_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_%0d got %b exp 1", k, bus.pe_req_ready_o); end
            next_cyc();
        end
        req(3'd6, 16'd9, 3'd0, 8'h00);
        mid();
        checks++; if (bus.pe_req_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready_low got %b exp 0", bus.pe_req_ready_o); end
        checks++; if (bus.vinsn_inflight_o !== 8'h0F) begin errors++; $display("FAIL full_inflight got %h exp 0f", bus.vinsn_inflight_o); end
        next_cyc();
        idle();
        bus.issue_ready_i = 1'b1;
        mid();
        checks++; if (bus.issue_valid_o !== 1'b1 || bus.issue_id_o !== 3'd0) begin errors++; $display("FAIL full_head got valid %b id %0d exp 1 0", bus.issue_valid_o, bus.issue_id_o); end
        next_cyc();
        bus.issue_ready_i = 1'b0;
        bus.exec_done_i = 1'b1;
        mid();
        checks++; if (bus.pe_req_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready_commit_cycle got %b exp 0", bus.pe_req_ready_o); end
        next_cyc();
        bus.exec_done_i = 1'b0;
        mid();
        checks++; if (bus.pe_req_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_after_commit got %b exp 1", bus.pe_req_ready_o); end
        checks++; if (bus.vinsn_done_o !== 8'h01 || bus.vinsn_inflight_o !== 8'h0E) begin errors++; $display("FAIL full_commit got done %h inflight %h exp 01 0e", bus.vinsn_done_o, bus.vinsn_inflight_o); end
        next_cyc();
        bus.issue_ready_i = 1'b1;
        for (int k = 1; k < 4; k++) begin
            mid();
            checks++; if (bus.issue_id_o !== 3'(k) || bus.issue_vl_o !== 16'(k + 1)) begin errors++; $display("FAIL full_drain_%0d got id %0d vl %0d exp %0d %0d", k, bus.issue_id_o, bus.issue_vl_o, k, k + 1); end
            next_cyc();
        end
        bus.issue_ready_i = 1'b0;
        bus.exec_done_i = 1'b1;
        for (int k = 0; k < 3; k++) next_cyc();
        bus.exec_done_i = 1'b0;
        mid();
        checks++; if (bus.vinsn_inflight_o !== 8'h00) begin errors++; $display("FAIL full_drained_inflight got %h exp 00", bus.vinsn_inflight_o); end
        next_cyc();
    endtask

    task automatic test_foreign_vfu();
        idle();
        bus.issue_ready_i = 1'b1;
        req(3'd1, 16'd5, 3'd2, 8'h00);
        mid();
        checks++; if (bus.pe_req_ready_o !== 1'b1 || bus.issue_valid_o !== 1'b0) begin errors++; $display("FAIL foreign_same_cycle got ready %b valid %b exp 1 0", bus.pe_req_ready_o, bus.issue_valid_o); end
        next_cyc();
        idle();
        mid();
        checks++; if (bus.issue_valid_o !== 1'b0 || bus.vinsn_inflight_o !== 8'h00) begin errors++; $display("FAIL foreign_no_entry got valid %b inflight %h exp 0 00", bus.issue_valid_o, bus.vinsn_inflight_o); end
        checks++; if (bus.pe_req_ready_o !== 1'b1) begin errors++; $display("FAIL foreign_ready got %b exp 1", bus.pe_req_ready_o); end
        next_cyc();
    endtask

    task automatic test_bypass();
        logic v0, v1;
        logic [2:0] i0, i1;
        idle();
        bus.issue_ready_i = 1'b1;
        req(3'd6, 16'd7, 3'd0, 8'h00);
        mid(); v0 = bus.issue_valid_o; i0 = bus.issue_id_o; next_cyc();
        idle();
        mid(); v1 = bus.issue_valid_o; i1 = bus.issue_id_o;
        checks++; if (v0 !== BYP || v1 !== !BYP) begin errors++; $display("FAIL bypass_latency got %b%b exp %b%b", v0, v1, BYP, !BYP); end
        checks++; if ((BYP ? i0 : i1) !== 3'd6) begin errors++; $display("FAIL bypass_id got %0d exp 6", BYP ? i0 : i1); end
        next_cyc();
        bus.issue_ready_i = 1'b0;
        bus.exec_done_i = 1'b1;
        next_cyc();
        bus.exec_done_i = 1'b0;
        mid();
        checks++; if (bus.vinsn_done_o !== 8'h40) begin errors++; $display("FAIL bypass_done got %h exp 40", bus.vinsn_done_o); end
        next_cyc();
    endtask

    task automatic test_reset_midop();
        idle();
        bus.issue_ready_i = 1'b1;
        req(3'd7, 16'd3, 3'd0, 8'h00);
        next_cyc();
        idle();
        next_cyc();
        bus.issue_ready_i = 1'b0;
        bus.exec_done_i = 1'b1;
        mid();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.vinsn_inflight_o !== 8'h00 || bus.issue_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_state got inflight %h valid %b exp 00 0", bus.vinsn_inflight_o, bus.issue_valid_o); end
        next_cyc();
        mid();
        checks++; if (bus.vinsn_done_o !== 8'h00) begin errors++; $display("FAIL rstmid_done got %h exp 00", bus.vinsn_done_o); end
        bus.exec_done_i = 1'b0;
        next_cyc();
        rst_n = 1'b1;
        next_cyc();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duplicate_hold();
        test_hazard();
        test_full();
        test_foreign_vfu();
        test_bypass();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
